// File: rtl/rad_injector_pkg.sv
// Shared types and default widths for the radiation mismatch injector.
package rad_injector_pkg;

  localparam int C_INJ_COUNT_WIDTH = 8;
  localparam int C_INJ_TIMER_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } t_inj_state;

endpackage

// File: rtl/rad_injector_phase_timer.sv
// Loadable phase down-counter shared by the HIGH and LOW phases.
// A length of 0 behaves like 1, so every phase lasts at least one cycle.
module rad_injector_phase_timer
  import rad_injector_pkg::*;
#(
  parameter int G_TIMER_WIDTH = C_INJ_TIMER_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     load,
  input  logic [G_TIMER_WIDTH-1:0] len,
  output logic                     expired
);

  localparam logic [G_TIMER_WIDTH-1:0] C_ONE = G_TIMER_WIDTH'(1);

  logic [G_TIMER_WIDTH-1:0] count;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count <= '0;
    end else if (load) begin
      count <= (len == '0) ? '0 : len - C_ONE;
    end else if (count != '0) begin
      count <= count - C_ONE;
    end
  end

  // The phase ends on the cycle the count sits at zero; it never wraps.
  assign expired = (count == '0);

endmodule

// File: rtl/radiation_mismatch_injector.sv
// Burst generator of rectangular mismatch pulses on a masked set of monitor channels.
// Handshake: start_i is accepted only while busy_o=0; busy_o stays high until the cycle
// after the one-cycle done_o strobe, and pulses_sent_o holds the burst's edge count until the next start.
module radiation_mismatch_injector
  import rad_injector_pkg::*;
#(
  parameter int G_NUM_CHANNELS = 4,
  parameter int G_COUNT_WIDTH  = C_INJ_COUNT_WIDTH,
  parameter int G_TIMER_WIDTH  = C_INJ_TIMER_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [G_COUNT_WIDTH-1:0]  num_pulses_i,
  input  logic [G_TIMER_WIDTH-1:0]  high_len_i,
  input  logic [G_TIMER_WIDTH-1:0]  low_len_i,
  input  logic [G_NUM_CHANNELS-1:0] chan_mask_i,
  output logic [G_NUM_CHANNELS-1:0] mismatch_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [G_COUNT_WIDTH-1:0]  pulses_sent_o,
  output t_inj_state                dbg_state_o
);

  localparam logic [G_COUNT_WIDTH-1:0] C_CNT_ONE = G_COUNT_WIDTH'(1);

  t_inj_state                state;
  logic [G_COUNT_WIDTH-1:0]  cfg_num;
  logic [G_TIMER_WIDTH-1:0]  cfg_high;
  logic [G_TIMER_WIDTH-1:0]  cfg_low;
  logic [G_NUM_CHANNELS-1:0] cfg_mask;

  logic                      timer_load;
  logic [G_TIMER_WIDTH-1:0]  timer_len;
  logic                      timer_expired;
  logic                      more_pulses;

  assign more_pulses = (pulses_sent_o < cfg_num);

  // Reload the shared timer on every phase entry; the first HIGH uses the live inputs.
  always_comb begin
    timer_load = 1'b0;
    timer_len  = cfg_high;
    case (state)
      IDLE: begin
        if (start_i && (num_pulses_i != '0)) begin
          timer_load = 1'b1;
          timer_len  = high_len_i;
        end
      end
      HIGH: begin
        if (!abort_i && timer_expired && more_pulses) begin
          timer_load = 1'b1;
          timer_len  = cfg_low;
        end
      end
      LOW: begin
        if (!abort_i && timer_expired) begin
          timer_load = 1'b1;
          timer_len  = cfg_high;
        end
      end
      default: ;
    endcase
  end

  rad_injector_phase_timer #(
    .G_TIMER_WIDTH(G_TIMER_WIDTH)
  ) u_phase_timer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load    (timer_load),
    .len     (timer_len),
    .expired (timer_expired)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      cfg_num       <= '0;
      cfg_high      <= '0;
      cfg_low       <= '0;
      cfg_mask      <= '0;
      mismatch_o    <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      pulses_sent_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          mismatch_o <= '0;
          busy_o     <= 1'b0;
          done_o     <= 1'b0;
          if (start_i) begin
            cfg_num  <= num_pulses_i;
            cfg_high <= high_len_i;
            cfg_low  <= low_len_i;
            cfg_mask <= chan_mask_i;
            busy_o   <= 1'b1;
            if (num_pulses_i == '0) begin
              state         <= DONE;
              done_o        <= 1'b1;
              pulses_sent_o <= '0;
            end else begin
              state         <= HIGH;
              mismatch_o    <= chan_mask_i;
              pulses_sent_o <= C_CNT_ONE;
            end
          end
        end
        HIGH: begin
          if (abort_i || (timer_expired && !more_pulses)) begin
            state      <= DONE;
            mismatch_o <= '0;
            done_o     <= 1'b1;
          end else if (timer_expired) begin
            state      <= LOW;
            mismatch_o <= '0;
          end
        end
        LOW: begin
          if (abort_i) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else if (timer_expired) begin
            state         <= HIGH;
            mismatch_o    <= cfg_mask;
            pulses_sent_o <= pulses_sent_o + C_CNT_ONE;
          end
        end
        DONE: begin
          state      <= IDLE;
          mismatch_o <= '0;
          done_o     <= 1'b0;
          busy_o     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state_o = state;

endmodule

// File: tb/tb_radiation_mismatch_injector.sv
// Directed bench for radiation_mismatch_injector with a formula-based burst model.
module tb_radiation_mismatch_injector;
  import rad_injector_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [7:0]  num_pulses_i = '0;
  logic [15:0] high_len_i = '0;
  logic [15:0] low_len_i = '0;
  logic [3:0]  chan_mask_i = '0;
  logic [3:0]  mismatch_o;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  pulses_sent_o;
  t_inj_state  dbg_state;

  radiation_mismatch_injector dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .num_pulses_i  (num_pulses_i),
    .high_len_i    (high_len_i),
    .low_len_i     (low_len_i),
    .chan_mask_i   (chan_mask_i),
    .mismatch_o    (mismatch_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .pulses_sent_o (pulses_sent_o),
    .dbg_state_o   (dbg_state)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // burst model: outputs as a function of cycles since the accepted start
  bit       m_valid = 1'b0;
  int       m_start = 0;
  int       m_n, m_h, m_l, m_abort;
  int       m_prev_sent = 0;
  logic [3:0] m_mask;

  function automatic int model_end();
    int hh, ll, d;
    hh = (m_h == 0) ? 1 : m_h;
    ll = (m_l == 0) ? 1 : m_l;
    d = (m_n == 0) ? 1 : m_n * hh + (m_n - 1) * ll + 1;
    if (m_abort >= 1 && m_abort < d) d = m_abort + 1;
    return d;
  endfunction

  task automatic model_eval(input int t, output logic [3:0] e_mm, output logic e_busy,
                            output logic e_done, output int e_sent);
    int hh, ll, p, d_end, fin;
    e_mm = '0; e_busy = 1'b0; e_done = 1'b0; e_sent = 0;
    if (!m_valid) return;
    if (t <= 0) begin
      e_sent = m_prev_sent;
      return;
    end
    hh = (m_h == 0) ? 1 : m_h;
    ll = (m_l == 0) ? 1 : m_l;
    p = hh + ll;
    d_end = model_end();
    fin = (d_end != ((m_n == 0) ? 1 : m_n * hh + (m_n - 1) * ll + 1)) ? (m_abort - 1) / p + 1 : m_n;
    if (t < d_end) begin
      e_mm = (((t - 1) % p) < hh) ? m_mask : 4'h0;
      e_busy = 1'b1;
      e_sent = (t - 1) / p + 1;
    end else if (t == d_end) begin
      e_busy = 1'b1;
      e_done = 1'b1;
      e_sent = fin;
    end else begin
      e_sent = fin;
    end
  endtask

  // scoreboard compare on every falling edge
  always @(negedge clk) begin
    logic [3:0] e_mm;
    logic e_busy, e_done;
    int e_sent;
    model_eval(cyc - m_start, e_mm, e_busy, e_done, e_sent);
    chk("mismatch", int'(mismatch_o), int'(e_mm));
    chk("busy", int'(busy_o), int'(e_busy));
    chk("done", int'(done_o), int'(e_done));
    chk("pulses_sent", int'(pulses_sent_o), e_sent);
    chk("idle_state", int'(dbg_state == IDLE), int'(!e_busy));
  end

  // driver tasks
  task automatic at_cycle(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic start_burst(input int n, input int h, input int l, input logic [3:0] mask,
                             input logic with_abort);
    logic [3:0] d_mm;
    logic d_b, d_d;
    int prev;
    @(posedge clk); #1;
    model_eval(cyc - m_start, d_mm, d_b, d_d, prev);
    m_prev_sent = prev;
    m_start = cyc; m_n = n; m_h = h; m_l = l; m_mask = mask; m_abort = -1;
    m_valid = 1'b1;
    num_pulses_i = 8'(n); high_len_i = 16'(h); low_len_i = 16'(l); chan_mask_i = mask;
    start_i = 1'b1;
    abort_i = with_abort;
    @(posedge clk); #1;
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic wait_end();
    at_cycle(m_start + model_end() + 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_mismatch", int'(mismatch_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_sent", int'(pulses_sent_o), 0);
    #19 rst_n = 1'b1;

    // N=3 H=2 L=3 mask 0101
    start_burst(3, 2, 3, 4'b0101, 1'b0);
    at_cycle(m_start + 1);  chk("b1_mm_c1", int'(mismatch_o), 5);
    at_cycle(m_start + 2);  chk("b1_mm_c2", int'(mismatch_o), 5);
    at_cycle(m_start + 3);  chk("b1_mm_c3", int'(mismatch_o), 0);
    at_cycle(m_start + 6);  chk("b1_mm_c6", int'(mismatch_o), 5);
    at_cycle(m_start + 11); chk("b1_mm_c11", int'(mismatch_o), 5);
    at_cycle(m_start + 12); chk("b1_mm_c12", int'(mismatch_o), 5);
    at_cycle(m_start + 13); chk("b1_done_c13", int'(done_o), 1);
    chk("b1_sent_c13", int'(pulses_sent_o), 3);
    at_cycle(m_start + 14); chk("b1_busy_c14", int'(busy_o), 0);

    // N=0 completes immediately
    start_burst(0, 7, 7, 4'hF, 1'b0);
    at_cycle(m_start + 1);
    chk("n0_done_c1", int'(done_o), 1);
    chk("n0_sent", int'(pulses_sent_o), 0);
    chk("n0_mm", int'(mismatch_o), 0);
    wait_end();

    // H=0 L=0 clamp to 1, start together with abort
    start_burst(4, 0, 0, 4'b0001, 1'b1);
    at_cycle(m_start + 2); chk("h0_mm_c2", int'(mismatch_o), 0);
    at_cycle(m_start + 7); chk("h0_mm_c7", int'(mismatch_o), 1);
    at_cycle(m_start + 8); chk("h0_done_c8", int'(done_o), 1);
    chk("h0_sent", int'(pulses_sent_o), 4);
    wait_end();

    // abort during the second pulse
    start_burst(10, 4, 4, 4'hC, 1'b0);
    at_cycle(m_start + 10);
    abort_i = 1'b1; m_abort = 10;
    @(posedge clk); #1 abort_i = 1'b0;
    at_cycle(m_start + 11);
    chk("ab_done_c11", int'(done_o), 1);
    chk("ab_mm_c11", int'(mismatch_o), 0);
    chk("ab_sent", int'(pulses_sent_o), 2);
    wait_end();

    // restart while busy is ignored
    start_burst(2, 2, 2, 4'h3, 1'b0);
    at_cycle(m_start + 3);
    num_pulses_i = 8'd9; high_len_i = 16'd1; low_len_i = 16'd1; chan_mask_i = 4'hF;
    start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    at_cycle(m_start + 5); chk("rs_mm_c5", int'(mismatch_o), 3);
    at_cycle(m_start + 7); chk("rs_done_c7", int'(done_o), 1);
    wait_end();

    // abort in DONE is ignored
    start_burst(1, 3, 1, 4'h6, 1'b0);
    at_cycle(m_start + 4);
    abort_i = 1'b1; m_abort = 4;
    @(posedge clk); #1 abort_i = 1'b0;
    at_cycle(m_start + 5); chk("ad_busy_c5", int'(busy_o), 0);
    wait_end();

    // zero mask still counts
    start_burst(2, 1, 2, 4'h0, 1'b0);
    at_cycle(m_start + 5); chk("m0_sent", int'(pulses_sent_o), 2);
    wait_end();

    // asynchronous reset mid-HIGH, then a normal burst
    start_burst(5, 6, 2, 4'hF, 1'b0);
    at_cycle(m_start + 2);
    #2 rst_n = 1'b0;
    m_valid = 1'b0; m_prev_sent = 0;
    #1;
    chk("ar_mm", int'(mismatch_o), 0);
    chk("ar_busy", int'(busy_o), 0);
    chk("ar_sent", int'(pulses_sent_o), 0);
    chk("ar_done", int'(done_o), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    start_burst(2, 1, 1, 4'hA, 1'b0);
    at_cycle(m_start + 1); chk("pr_mm_c1", int'(mismatch_o), 10);
    at_cycle(m_start + 3); chk("pr_mm_c3", int'(mismatch_o), 10);
    chk("pr_sent_c3", int'(pulses_sent_o), 2);
    at_cycle(m_start + 4); chk("pr_done_c4", int'(done_o), 1);
    wait_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
